// File: rtl/uart_line_rx.sv
// 8N1 UART receiver that assembles bytes into a line buffer and holds each '\n'-terminated line
// until acknowledged. Optional macro UART_LINE_STRIP_CR_EN drops 0x0D bytes before assembly.
module uart_line_rx #(
  parameter int CLK_FRE   = 50,
  parameter int UART_RATE = 115200,
  parameter int MAX_LEN   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rx_pin,
  output logic                         line_valid,
  output logic [$clog2(MAX_LEN+1)-1:0] line_len,
  output logic                         line_trunc,
  input  logic                         line_ack,
  input  logic [$clog2(MAX_LEN)-1:0]   rd_addr,
  output logic [7:0]                   rd_data,
  output logic                         frame_err,
  output logic                         overrun
);

  localparam int BIT_CYC = CLK_FRE * 1000000 / UART_RATE;
  localparam int HALF    = BIT_CYC / 2;
  localparam int LW      = $clog2(MAX_LEN + 1);
  localparam int AW      = $clog2(MAX_LEN);
  localparam logic [15:0] BIT_LAST  = 16'(BIT_CYC - 1);
  localparam logic [15:0] HALF_LAST = 16'(HALF - 1);

  typedef enum logic [2:0] {ST_ARM, ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

  state_t          state_r, state_nx_s;
  logic [15:0]     cnt_r, cnt_nx_s;
  logic [2:0]      bit_idx_r, bit_idx_nx_s;
  logic [7:0]      shift_r, shift_nx_s;
  logic [1:0]      sync_r;
  logic            rxs_s;
  logic            byte_good_s, stop_bad_s, byte_keep_s, buf_we_s;

  logic            line_valid_r, line_trunc_r, trunc_flag_r;
  logic [LW-1:0]   line_len_r, wr_ptr_r;
  logic [7:0]      rd_data_r;
  logic            frame_err_r, overrun_r;
  logic [7:0]      line_buf_r [MAX_LEN];

  assign rxs_s = sync_r[1];

  // Two-flop synchronizer, reset to the idle-high line level
  always_ff @(posedge clk) begin
    if (rst) sync_r <= 2'b11;
    else     sync_r <= {sync_r[0], rx_pin};
  end

  // Receiver state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_ARM;
      cnt_r     <= 16'd0;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
    end else begin
      state_r   <= state_nx_s;
      cnt_r     <= cnt_nx_s;
      bit_idx_r <= bit_idx_nx_s;
      shift_r   <= shift_nx_s;
    end
  end

  // Receiver next-state: ARM waits for a full idle-high bit so a mid-frame reset never false-starts
  always_comb begin
    state_nx_s   = state_r;
    cnt_nx_s     = cnt_r + 16'd1;
    bit_idx_nx_s = bit_idx_r;
    shift_nx_s   = shift_r;
    byte_good_s  = 1'b0;
    stop_bad_s   = 1'b0;
    case (state_r)
      ST_ARM: begin
        if (!rxs_s) begin
          cnt_nx_s = 16'd0;
        end else if (cnt_r == BIT_LAST) begin
          cnt_nx_s   = 16'd0;
          state_nx_s = ST_IDLE;
        end else begin
          cnt_nx_s = cnt_r + 16'd1;
        end
      end
      ST_IDLE: begin
        cnt_nx_s = 16'd0;
        if (!rxs_s) state_nx_s = ST_START;
        else        state_nx_s = ST_IDLE;
      end
      ST_START: begin
        if (cnt_r == HALF_LAST) begin
          cnt_nx_s     = 16'd0;
          bit_idx_nx_s = 3'd0;
          if (!rxs_s) state_nx_s = ST_DATA;
          else        state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_START;
        end
      end
      ST_DATA: begin
        if (cnt_r == BIT_LAST) begin
          cnt_nx_s     = 16'd0;
          shift_nx_s   = {rxs_s, shift_r[7:1]};
          bit_idx_nx_s = bit_idx_r + 3'd1;
          if (bit_idx_r == 3'd7) state_nx_s = ST_STOP;
          else                   state_nx_s = ST_DATA;
        end else begin
          state_nx_s = ST_DATA;
        end
      end
      ST_STOP: begin
        if (cnt_r == BIT_LAST) begin
          cnt_nx_s = 16'd0;
          if (rxs_s) begin
            byte_good_s = 1'b1;
            state_nx_s  = ST_IDLE;
          end else begin
            stop_bad_s = 1'b1;
            state_nx_s = ST_ARM;
          end
        end else begin
          state_nx_s = ST_STOP;
        end
      end
      default: begin
        state_nx_s = ST_ARM;
        cnt_nx_s   = 16'd0;
      end
    endcase
  end

`ifdef UART_LINE_STRIP_CR_EN
  assign byte_keep_s = byte_good_s && (shift_r != 8'h0D);
`else
  assign byte_keep_s = byte_good_s;
`endif

  assign buf_we_s = byte_keep_s && !line_valid_r && (shift_r != 8'h0A) &&
                    (wr_ptr_r < LW'(MAX_LEN));

  // Line assembly and hold/ack handshake; a byte arriving with the ack still sees the held line
  always_ff @(posedge clk) begin
    if (rst) begin
      line_valid_r <= 1'b0;
      line_len_r   <= '0;
      line_trunc_r <= 1'b0;
      wr_ptr_r     <= '0;
      trunc_flag_r <= 1'b0;
      frame_err_r  <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      frame_err_r <= stop_bad_s;
      overrun_r   <= byte_keep_s && line_valid_r;
      if (line_valid_r) begin
        if (line_ack) begin
          line_valid_r <= 1'b0;
          line_len_r   <= '0;
          line_trunc_r <= 1'b0;
        end
      end else if (byte_keep_s) begin
        if (shift_r == 8'h0A) begin
          line_valid_r <= 1'b1;
          line_len_r   <= wr_ptr_r;
          line_trunc_r <= trunc_flag_r;
          wr_ptr_r     <= '0;
          trunc_flag_r <= 1'b0;
        end else if (wr_ptr_r < LW'(MAX_LEN)) begin
          wr_ptr_r <= wr_ptr_r + LW'(1);
        end else begin
          trunc_flag_r <= 1'b1;
        end
      end
    end
  end

  // Line buffer storage; contents survive reset and ack
  always_ff @(posedge clk) begin
    if (buf_we_s && !rst) line_buf_r[wr_ptr_r[AW-1:0]] <= shift_r;
  end

  // Registered read port
  always_ff @(posedge clk) begin
    if (rst) rd_data_r <= 8'h00;
    else     rd_data_r <= line_buf_r[rd_addr];
  end

  assign line_valid = line_valid_r;
  assign line_len   = line_len_r;
  assign line_trunc = line_trunc_r;
  assign rd_data    = rd_data_r;
  assign frame_err  = frame_err_r;
  assign overrun    = overrun_r;

endmodule

// File: tb/tb_uart_line_rx.sv
// Self-checking bench for uart_line_rx: serial stimulus against a line-level reference model.
// Runs with a 32-cycle bit time to keep simulation short; honours UART_LINE_STRIP_CR_EN.
module tb_uart_line_rx;

  localparam int BIT  = 32;
  localparam int MAXL = 16;

  logic       clk = 1'b0;
  logic       rst, rx_pin, line_ack;
  logic [3:0] rd_addr;
  logic       line_valid, line_trunc, frame_err, overrun;
  logic [4:0] line_len;
  logic [7:0] rd_data;

  int tests_run = 0;
  int tests_failed = 0;
  int fe_cnt = 0;
  int ovr_cnt = 0;

  // Reference model state
  logic       m_valid, m_trunc, m_tf;
  int         m_len, m_wr, m_fe, m_ovr;
  logic [7:0] m_buf [MAXL];

  uart_line_rx #(.CLK_FRE(50), .UART_RATE(1562500), .MAX_LEN(MAXL)) dut (
    .clk(clk), .rst(rst), .rx_pin(rx_pin),
    .line_valid(line_valid), .line_len(line_len), .line_trunc(line_trunc),
    .line_ack(line_ack), .rd_addr(rd_addr), .rd_data(rd_data),
    .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (overrun)   ovr_cnt <= ovr_cnt + 1;
  end

  initial begin
    repeat (150000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_valid = 1'b0; m_trunc = 1'b0; m_tf = 1'b0;
    m_len = 0; m_wr = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
`ifdef UART_LINE_STRIP_CR_EN
    if (b == 8'h0D) return;
`endif
    if (m_valid) m_ovr++;
    else if (b == 8'h0A) begin
      m_valid = 1'b1; m_len = m_wr; m_trunc = m_tf; m_wr = 0; m_tf = 1'b0;
    end else if (m_wr < MAXL) begin
      m_buf[m_wr] = b; m_wr++;
    end else m_tf = 1'b1;
  endtask

  task automatic idle(input int n);
    rx_pin = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b);
    rx_pin = b;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
    if (stop) model_byte(b);
    else begin
      m_fe++;
      idle(2 * BIT);
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask

  task automatic ack();
    line_ack = 1'b1;
    @(negedge clk);
    line_ack = 1'b0;
    if (m_valid) begin
      m_valid = 1'b0; m_len = 0; m_trunc = 1'b0;
    end
  endtask

  task automatic read_byte(input int a, output logic [7:0] d);
    rd_addr = 4'(a);
    @(negedge clk);
    d = rd_data;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_pin = 1'b1; line_ack = 1'b0; rd_addr = 4'd0;
    m_fe = 0; m_ovr = 0;
    model_reset();
    repeat (3) @(negedge clk);
    tests_run++;
    if ({line_valid, line_len, line_trunc, rd_data, frame_err, overrun} !== 17'd0) begin
      tests_failed++;
      $display("FAIL reset_values: got v=%b len=%0d tr=%b rd=%h fe=%b ov=%b want all zero",
               line_valid, line_len, line_trunc, rd_data, frame_err, overrun);
    end
    rst = 1'b0;
    idle(2 * BIT);
  endtask

  task automatic test_abc();
    logic [7:0] d;
    send_str("A");
    ack();  // ignored: no line held
    send_str("BC\n");
    tests_run++;
    if (line_valid !== 1'b1 || line_len !== 5'(m_len) || line_trunc !== 1'b0) begin
      tests_failed++;
      $display("FAIL abc_line: got v=%b len=%0d tr=%b want v=1 len=3 tr=0", line_valid, line_len, line_trunc);
    end
    for (int i = 0; i < 3; i++) begin
      read_byte(i, d);
      tests_run++;
      if (d !== m_buf[i]) begin
        tests_failed++;
        $display("FAIL abc_data[%0d]: got %h want %h", i, d, m_buf[i]);
      end
    end
    ack();
    tests_run++;
    if (line_valid !== 1'b0 || line_len !== 5'd0) begin
      tests_failed++;
      $display("FAIL abc_ack: got v=%b len=%0d want v=0 len=0", line_valid, line_len);
    end
  endtask

  task automatic test_truncation();
    logic [7:0] d;
    for (int i = 0; i < 20; i++) send_byte(8'h30 + 8'(i), 1'b1);
    send_byte(8'h0A, 1'b1);
    tests_run++;
    if (line_valid !== 1'b1 || line_len !== 5'd16 || line_trunc !== 1'b1) begin
      tests_failed++;
      $display("FAIL trunc_line: got v=%b len=%0d tr=%b want v=1 len=16 tr=1", line_valid, line_len, line_trunc);
    end
    read_byte(15, d);
    tests_run++;
    if (d !== 8'h3F || d !== m_buf[15]) begin
      tests_failed++;
      $display("FAIL trunc_buf15: got %h want 3f", d);
    end
    read_byte(0, d);
    tests_run++;
    if (d !== m_buf[0]) begin
      tests_failed++;
      $display("FAIL trunc_buf0: got %h want %h", d, m_buf[0]);
    end
    ack();
    tests_run++;
    if (line_valid !== 1'b0 || line_len !== 5'd0 || line_trunc !== 1'b0) begin
      tests_failed++;
      $display("FAIL trunc_ack: got v=%b len=%0d tr=%b want 0/0/0", line_valid, line_len, line_trunc);
    end
  endtask

  task automatic test_overrun();
    send_str("X\n");
    send_str("Z");
    tests_run++;
    if (ovr_cnt !== m_ovr || line_valid !== 1'b1 || line_len !== 5'(m_len)) begin
      tests_failed++;
      $display("FAIL overrun: got pulses=%0d v=%b len=%0d want pulses=%0d v=1 len=%0d",
               ovr_cnt, line_valid, line_len, m_ovr, m_len);
    end
    ack();
    ack();  // second ack with nothing held
    send_str("\n");
    tests_run++;
    if (line_valid !== 1'b1 || line_len !== 5'd0 || line_trunc !== 1'b0) begin
      tests_failed++;
      $display("FAIL empty_line: got v=%b len=%0d tr=%b want v=1 len=0 tr=0", line_valid, line_len, line_trunc);
    end
    ack();
  endtask

  task automatic test_frame_err();
    logic [7:0] d;
    send_byte(8'h55, 1'b0);
    tests_run++;
    if (fe_cnt !== m_fe || line_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL frame_err: got pulses=%0d v=%b want pulses=%0d v=0", fe_cnt, line_valid, m_fe);
    end
    send_str("Q\n");
    read_byte(0, d);
    tests_run++;
    if (line_len !== 5'd1 || d !== 8'h51) begin
      tests_failed++;
      $display("FAIL after_ferr: got len=%0d buf0=%h want len=1 buf0=51", line_len, d);
    end
    ack();
  endtask

  task automatic test_glitch();
    rx_pin = 1'b0;
    repeat (BIT / 4) @(negedge clk);
    idle(3 * BIT);
    tests_run++;
    if (fe_cnt !== m_fe || line_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL glitch: got ferr=%0d v=%b want ferr=%0d v=0", fe_cnt, line_valid, m_fe);
    end
    send_str("\n");
    tests_run++;
    if (line_valid !== 1'b1 || line_len !== 5'd0) begin
      tests_failed++;
      $display("FAIL glitch_nobyte: got v=%b len=%0d want v=1 len=0", line_valid, line_len);
    end
    ack();
  endtask

  task automatic test_cr_and_reset();
    logic [7:0] d;
    int exp_len;
`ifdef UART_LINE_STRIP_CR_EN
    exp_len = 2;
`else
    exp_len = 3;
`endif
    send_str("OK\r\n");
    tests_run++;
    if (line_len !== 5'(exp_len) || line_len !== 5'(m_len)) begin
      tests_failed++;
      $display("FAIL cr_len: got %0d want %0d", line_len, exp_len);
    end
    read_byte(exp_len - 1, d);
    tests_run++;
    if (d !== m_buf[exp_len - 1]) begin
      tests_failed++;
      $display("FAIL cr_last: got %h want %h", d, m_buf[exp_len - 1]);
    end
    // Reset in the middle of data bit 4 of byte 0x0F
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    rx_pin = 1'b0;
    repeat (BIT / 2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({line_valid, line_len, line_trunc, rd_data, frame_err, overrun} !== 17'd0) begin
      tests_failed++;
      $display("FAIL midframe_reset: got v=%b len=%0d tr=%b rd=%h fe=%b ov=%b want all zero",
               line_valid, line_len, line_trunc, rd_data, frame_err, overrun);
    end
    rst = 1'b0;
    model_reset();
    repeat (BIT / 2 - 2) @(negedge clk);
    for (int i = 0; i < 3; i++) drive_bit(1'b0);
    drive_bit(1'b1);
    idle(2 * BIT);
    send_str("\n");
    tests_run++;
    if (fe_cnt !== m_fe || ovr_cnt !== m_ovr || line_valid !== 1'b1 || line_len !== 5'd0) begin
      tests_failed++;
      $display("FAIL post_reset: got ferr=%0d ovr=%0d v=%b len=%0d want ferr=%0d ovr=%0d v=1 len=0",
               fe_cnt, ovr_cnt, line_valid, line_len, m_fe, m_ovr);
    end
    ack();
  endtask

  task automatic test_random_lines();
    logic [7:0] d;
    int n;
    for (int k = 0; k < 5; k++) begin
      n = $urandom_range(0, 20);
      for (int i = 0; i < n; i++) send_byte(8'($urandom_range(32'h20, 32'h7E)), 1'b1);
      send_byte(8'h0A, 1'b1);
      if ($urandom_range(0, 1) == 1) send_byte(8'($urandom_range(32'h20, 32'h7E)), 1'b1);
      tests_run++;
      if (line_valid !== m_valid || line_len !== 5'(m_len) || line_trunc !== m_trunc ||
          ovr_cnt !== m_ovr) begin
        tests_failed++;
        $display("FAIL rand_line%0d: got v=%b len=%0d tr=%b ovr=%0d want v=%b len=%0d tr=%b ovr=%0d",
                 k, line_valid, line_len, line_trunc, ovr_cnt, m_valid, m_len, m_trunc, m_ovr);
      end
      for (int i = 0; i < m_len; i++) begin
        read_byte(i, d);
        tests_run++;
        if (d !== m_buf[i]) begin
          tests_failed++;
          $display("FAIL rand_data%0d[%0d]: got %h want %h", k, i, d, m_buf[i]);
        end
      end
      ack();
    end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_truncation();
    test_overrun();
    test_frame_err();
    test_glitch();
    test_cr_and_reset();
    test_random_lines();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_line_rx.md
# uart_line_rx

Line-oriented UART receiver: the receiving end of the board's 8N1 serial link. It deframes bytes from `rx_pin` and assembles them into a line buffer of up to `MAX_LEN` bytes. When a `'\n'` terminator arrives, it presents the completed line to a consumer through a hold/acknowledge handshake. It sits beside the existing UART transmit path and replaces the bare byte receiver wherever logic consumes text commands.

## Interface
- `CLK_FRE`, 50: clock frequency in MHz.
- `UART_RATE`, 115200: baud rate.
- `MAX_LEN`, 16: line buffer depth in bytes, ≥ 2.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rx_pin`  in  1  asynchronous serial input, idle high.
- `line_valid`  out  1  a completed line is held; high until `line_ack`.
- `line_len`  out  $clog2(MAX_LEN+1)  byte count of the held line, terminator excluded.
- `line_trunc`  out  1  the held line exceeded `MAX_LEN`; excess bytes were dropped.
- `line_ack`  in  1  one-cycle pulse; releases the held line.
- `rd_addr`  in  $clog2(MAX_LEN)  buffer read index.
- `rd_data`  out  8  buffer byte at `rd_addr`, registered.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: a byte completed while `line_valid` was high.

## Operation
- `BIT_CYC` = CLK_FRE*1_000_000/UART_RATE, integer division (434 at defaults). `HALF` = BIT_CYC/2 (217). The bit counter is 16 bits wide.
- `rx_pin` passes through a 2-FF synchronizer. All decisions use the synchronized value `rxs`.
- Receiver FSM:
  - ARM: count consecutive cycles with `rxs`=1; any 0 restarts the count. At BIT_CYC go to IDLE. ARM is the reset state.
  - IDLE: `rxs`=0 → START, counter cleared.
  - START: at count HALF-1 sample `rxs`. If 0 → DATA. If 1 (glitch) → IDLE.
  - DATA: every BIT_CYC cycles sample one bit, LSB first. After 8 samples → STOP.
  - STOP: after BIT_CYC cycles sample `rxs`. If 1, the byte is good. If 0, pulse `frame_err`, discard the byte, go to ARM. From a good stop go to IDLE in the same cycle as the sample.
- Line assembly on a good byte:
  - If `line_valid`=1: drop the byte and pulse `overrun`.
  - Else if byte = 0x0A: set `line_valid`, latch `line_len` = write pointer, latch `line_trunc`, reset the write pointer.
  - Else if write pointer < MAX_LEN: store the byte and increment the pointer.
  - Else: drop the byte and set the internal truncation flag.
- An empty line (a bare 0x0A) gives `line_valid` with `line_len`=0.
- `line_ack` while `line_valid`=1: clear `line_valid`, `line_len` and `line_trunc` next cycle. Buffer contents are not cleared. `line_ack` while `line_valid`=0 is ignored.
- A good byte and `line_ack` in the same cycle: the byte is evaluated against the pre-ack `line_valid`. It is dropped and `overrun` pulses.
- Bytes after the terminator of a held line accumulate nowhere. The next line starts at pointer 0 after ack.

## Timing
- Reset values: `line_valid`=0, `line_len`=0, `line_trunc`=0, `rd_data`=0x00, `frame_err`=0, `overrun`=0. The FSM goes to ARM, the write pointer and truncation flag clear, and the buffer is not cleared.
- Reset mid-frame aborts the byte. The receiver re-arms only after one full idle-high bit time, so a reset inside a frame cannot cause false starts on data bits.
- Sample point: start-bit centre at HALF cycles (+2 synchronizer) after the falling edge, then every BIT_CYC.
- `line_valid` rises 1 cycle after the stop-bit sample of the 0x0A byte.
- `rd_data` = buf[`rd_addr`] 1 cycle after `rd_addr` is applied. Reads are valid at any time. Addresses ≥ `line_len` return stale data.
- `frame_err` and `overrun` each pulse for exactly 1 cycle, 1 cycle after the stop sample.

## Configuration
- `UART_LINE_STRIP_CR_EN` defined: good bytes equal to 0x0D are discarded before line assembly. They are not stored, not counted and do not cause truncation. A "\r\n" ending yields the text-only length.
- Undefined: 0x0D is stored like any other byte.

## Test plan
- Send "ABC\n" at 115200 with 434-cycle bits → `line_valid`=1, `line_len`=3, `line_trunc`=0. `rd_addr` 0..2 returns 0x41, 0x42, 0x43.
- Send 20 bytes 0x30..0x43 then "\n" with MAX_LEN=16 → `line_len`=16, `line_trunc`=1, buf[15]=0x3F. `line_ack` clears all three outputs next cycle.
- With a line held, send "Z" → `overrun` pulses once and `line_valid` stays 1. After ack, send "\n" → `line_len`=0.
- Send byte 0x55 with stop bit forced low → one `frame_err` pulse, nothing stored. A following "Q\n" gives `line_len`=1 and buf[0]=0x51.
- Drive `rx_pin` low for 100 cycles, then high → START rejects the glitch. No byte, no `frame_err`.
- Send "OK\r\n" → `line_len`=2 with `UART_LINE_STRIP_CR_EN` defined, 3 (buf[2]=0x0D) without. Assert `rst` during bit 4 of the next byte → outputs at reset values and no spurious byte after release.
